// File: rtl/sd_out_sched.sv
// Round-robin scheduler sharing the host response path among NSD SD channel output buffers.
// Each grant emits one framed chunk (channel header, length header, up to MAX_CHUNK data words).
module sd_out_sched #(
    parameter int NSD       = 4,
    parameter int ADDR_BITS = 11,
    parameter int MAX_CHUNK = 64,
    parameter int RSP_CODE  = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NSD-1:0]           ch_start,
    input  logic [NSD*ADDR_BITS-1:0] ch_elemcnt,
    input  logic [NSD*8-1:0]         ch_data,
    output logic [NSD-1:0]           ch_advance,
    output logic                     invol_req,
    input  logic                     invol_grant,
    output logic [32:0]              param_data,
    output logic                     param_write,
    output logic                     done,
    output logic                     busy
);

    localparam int SEL_W = (NSD > 1) ? $clog2(NSD) : 1;
    localparam logic [ADDR_BITS-1:0] CHUNK_MAX = ADDR_BITS'(MAX_CHUNK);
    localparam logic [32:0] RSP_WORD = 33'(RSP_CODE);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        HDR_CH,
        HDR_LEN,
        WAIT1,
        WAIT2,
        DATA,
        FIN
    } state_t;

    state_t               state;
    logic [NSD-1:0]       pending;
    logic [NSD-1:0]       clr_mask;
    logic [NSD-1:0]       rq_mask;
    logic [SEL_W-1:0]     rr_ptr;
    logic [SEL_W-1:0]     sel;
    logic [SEL_W-1:0]     pick;
    logic [ADDR_BITS-1:0] len;
    logic [ADDR_BITS-1:0] rem;
    logic [ADDR_BITS-1:0] cnt_sel;
    logic [ADDR_BITS-1:0] len_nxt;
    logic [7:0]           byte_sel;

    // First pending channel strictly after ptr, wrapping modulo NSD; ptr itself is searched last.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NSD-1:0] req,
                                                 input logic [SEL_W-1:0] ptr);
        logic [SEL_W-1:0] win;
        int idx;
        win = ptr;
        for (int k = NSD; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NSD;
            if (req[idx]) win = SEL_W'(idx);
        end
        return win;
    endfunction

    function automatic logic [ADDR_BITS-1:0] clamp_len(input logic [ADDR_BITS-1:0] cnt);
        return (cnt > CHUNK_MAX) ? CHUNK_MAX : cnt;
    endfunction

    always_comb begin
        cnt_sel  = '0;
        byte_sel = '0;
        for (int i = 0; i < NSD; i++) begin
            if (sel == SEL_W'(i)) begin
                cnt_sel  = ch_elemcnt[i*ADDR_BITS +: ADDR_BITS];
                byte_sel = ch_data[i*8 +: 8];
            end
        end
    end

    assign pick    = rr_pick(pending, rr_ptr);
    assign len_nxt = clamp_len(cnt_sel);
    assign busy    = (state != IDLE);

    // New starts are OR-ed in after the clear so a coincident start is never lost.
    always_comb begin
        clr_mask = '0;
        rq_mask  = '0;
        if (state == REQ && invol_grant) clr_mask = NSD'(1) << pick;
        if (state == FIN && rem != '0)   rq_mask  = NSD'(1) << sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pending     <= '0;
            rr_ptr      <= SEL_W'(NSD - 1);
            sel         <= '0;
            len         <= '0;
            rem         <= '0;
            ch_advance  <= '0;
            invol_req   <= 1'b0;
            param_data  <= '0;
            param_write <= 1'b0;
            done        <= 1'b0;
        end else begin
            pending     <= (pending & ~clr_mask) | rq_mask | ch_start;
            param_write <= 1'b0;
            ch_advance  <= '0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    // Looking at ch_start directly lets the request rise the cycle after the pulse.
                    if ((pending | ch_start) != '0) begin
                        invol_req <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (invol_grant) begin
                        invol_req   <= 1'b0;
                        sel         <= pick;
                        rr_ptr      <= pick;
                        param_data  <= {1'b0, 32'(pick)};
                        param_write <= 1'b1;
                        state       <= HDR_CH;
                    end
                end
                HDR_CH: begin
                    len         <= len_nxt;
                    rem         <= cnt_sel - len_nxt;
                    param_data  <= {1'b1, 32'(len_nxt)};
                    param_write <= 1'b1;
                    state       <= HDR_LEN;
                end
                HDR_LEN: state <= WAIT1;
                WAIT1:   state <= WAIT2;
                WAIT2:   state <= DATA;
                DATA: begin
                    if (len == '0) begin
                        done       <= 1'b1;
                        param_data <= RSP_WORD;
                        state      <= FIN;
                    end else begin
                        param_data  <= {1'b1, 24'h0, byte_sel};
                        param_write <= 1'b1;
                        ch_advance  <= NSD'(1) << sel;
                        len         <= len - ADDR_BITS'(1);
                        state       <= WAIT1;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_out_sched.sv
// Bench for sd_out_sched: table vectors, hand-built corner sequences and randomized
// multi-channel rounds checked against a transaction-level scheduling model.
module tb_sd_out_sched;

    localparam int NSD = 4;
    localparam int AB  = 11;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NSD-1:0]     ch_start = '0;
    logic [NSD*AB-1:0]  ch_elemcnt;
    logic [NSD*8-1:0]   ch_data;
    logic [NSD-1:0]     ch_advance;
    logic               invol_req;
    logic               invol_grant;
    logic [32:0]        param_data;
    logic               param_write;
    logic               done;
    logic               busy;

    always #5 clk = ~clk;

    sd_out_sched #(.NSD(NSD), .ADDR_BITS(AB), .MAX_CHUNK(64), .RSP_CODE(0)) dut (
        .clk(clk), .rst_n(rst_n), .ch_start(ch_start), .ch_elemcnt(ch_elemcnt),
        .ch_data(ch_data), .ch_advance(ch_advance), .invol_req(invol_req),
        .invol_grant(invol_grant), .param_data(param_data), .param_write(param_write),
        .done(done), .busy(busy)
    );

    // Channel FIFO stand-ins: bytes are appended at size, popped at head.
    logic [7:0] mem [NSD][1024];
    int         size [NSD];
    int         head [NSD];
    logic       flush = 1'b0;

    always @(posedge clk)
        for (int i = 0; i < NSD; i++)
            if (flush) head[i] <= size[i];
            else if (ch_advance[i]) head[i] <= head[i] + 1;

    always_comb begin
        ch_elemcnt = '0;
        ch_data    = '0;
        for (int i = 0; i < NSD; i++) begin
            ch_elemcnt[i*AB +: AB] = AB'(size[i] - head[i]);
            ch_data[i*8 +: 8]      = mem[i][head[i] % 1024];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor
    logic [32:0] obs_w[$];
    int          obs_wc[$];
    int          adv_t[$];
    int          adv_cnt [NSD];
    int          n_done = 0;
    int          multi_adv = 0;
    int          rsp_bad = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (param_write) begin
                obs_w.push_back(param_data);
                obs_wc.push_back(cyc);
            end
            if (done) n_done <= n_done + 1;
            if (done && param_data !== 33'd0) rsp_bad <= rsp_bad + 1;
            if (!$onehot0(ch_advance)) multi_adv <= multi_adv + 1;
            for (int i = 0; i < NSD; i++)
                if (ch_advance[i]) begin
                    adv_cnt[i] <= adv_cnt[i] + 1;
                    adv_t.push_back(cyc);
                end
        end
    end

    // Host side: grant gnt_delay cycles after seeing a request, for one cycle.
    int gnt_delay = 0;
    int g_cyc = 0;
    initial begin
        int gwait;
        gwait = 0;
        invol_grant = 1'b0;
        forever begin
            @(negedge clk);
            if (invol_grant) invol_grant = 1'b0;
            else if (invol_req && rst_n) begin
                if (gwait >= gnt_delay) begin
                    invol_grant = 1'b1;
                    g_cyc = cyc;
                    gwait = 0;
                end else gwait++;
            end else gwait = 0;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    function automatic logic [32:0] word_at(input int idx);
        if (idx < obs_w.size()) return obs_w[idx];
        return 'x;
    endfunction

    // Reference model: transaction-level round-robin with chunking.
    int          m_rr;
    logic [NSD-1:0] m_pend;
    int          m_rem [NSD];
    logic [7:0]  m_q [NSD][$];
    logic [32:0] exp_words[$];
    int          exp_chunks;

    task automatic model_run();
        int c;
        int ln;
        logic [7:0] b;
        while (m_pend != '0) begin
            c = -1;
            for (int k = 1; k <= NSD; k++)
                if (c < 0 && m_pend[(m_rr + k) % NSD]) c = (m_rr + k) % NSD;
            m_pend[c] = 1'b0;
            m_rr = c;
            ln = (m_rem[c] > 64) ? 64 : m_rem[c];
            exp_words.push_back({1'b0, 32'(c)});
            exp_words.push_back({1'b1, 32'(ln)});
            for (int j = 0; j < ln; j++) begin
                b = m_q[c].pop_front();
                exp_words.push_back({1'b1, 24'h0, b});
            end
            m_rem[c] -= ln;
            exp_chunks++;
            if (m_rem[c] > 0) m_pend[c] = 1'b1;
        end
    endtask

    task automatic push_byte(input int ch, input logic [7:0] b);
        mem[ch][size[ch] % 1024] = b;
        size[ch]++;
        m_q[ch].push_back(b);
        m_rem[ch]++;
    endtask

    task automatic load_ch(input int ch, input int cnt);
        for (int k = 0; k < cnt; k++) push_byte(ch, 8'($urandom));
    endtask

    task automatic reset_all();
        @(negedge clk);
        rst_n = 1'b0;
        flush = 1'b1;
        ch_start = '0;
        repeat (2) @(negedge clk);
        flush = 1'b0;
        rst_n = 1'b1;
        m_rr = NSD - 1;
        m_pend = '0;
        exp_words.delete();
        exp_chunks = 0;
        for (int i = 0; i < NSD; i++) begin
            m_rem[i] = 0;
            m_q[i].delete();
        end
    endtask

    task automatic pulse_start(input logic [NSD-1:0] mask);
        @(negedge clk);
        ch_start = mask;
        @(negedge clk);
        ch_start = '0;
        m_pend |= mask;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 4 && n < budget) begin
            @(negedge clk);
            n++;
            if (!busy && !invol_req) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) timeout_fail(name);
    endtask

    task automatic wait_adv(input string name);
        int n;
        n = 0;
        while (ch_advance == '0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (ch_advance == '0) timeout_fail(name);
    endtask

    task automatic check_stream(input int base, input string name);
        int n;
        int bad;
        n = obs_w.size() - base;
        bad = -1;
        n_vec++;
        if (n != exp_words.size()) begin
            n_err++;
            $display("FAIL %s: got %0d words, expected %0d", name, n, exp_words.size());
        end else begin
            for (int i = 0; i < n; i++)
                if (bad < 0 && obs_w[base + i] !== exp_words[i]) bad = i;
            if (bad >= 0) begin
                n_err++;
                $display("FAIL %s: word %0d got 0x%0h, expected 0x%0h",
                         name, bad, obs_w[base + bad], exp_words[bad]);
            end
        end
    endtask

    int got_ch[$];
    int got_len[$];
    task automatic parse_hdrs(input int base);
        logic [32:0] w;
        got_ch.delete();
        got_len.delete();
        for (int i = base; i < obs_w.size(); i++) begin
            if (obs_w[i][32] == 1'b0) begin
                got_ch.push_back(int'(obs_w[i][31:0]));
                w = word_at(i + 1);
                got_len.push_back(int'(w[31:0]));
            end
        end
    endtask

    typedef struct {
        int ch;
        int cnt;
        int gdly;
        int exp_len;
        int exp_chunks;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int base;
        int ab;
        int d0;
        int a0;
        int cnts [NSD];
        logic [NSD-1:0] mask;

        tbl[0] = '{ch: 2, cnt: 3,   gdly: 5, exp_len: 3,  exp_chunks: 1};
        tbl[1] = '{ch: 1, cnt: 0,   gdly: 1, exp_len: 0,  exp_chunks: 1};
        tbl[2] = '{ch: 0, cnt: 130, gdly: 0, exp_len: 64, exp_chunks: 3};
        tbl[3] = '{ch: 3, cnt: 64,  gdly: 2, exp_len: 64, exp_chunks: 1};
        tbl[4] = '{ch: 1, cnt: 65,  gdly: 3, exp_len: 64, exp_chunks: 2};
        tbl[5] = '{ch: 0, cnt: 1,   gdly: 0, exp_len: 1,  exp_chunks: 1};

        // Reset state
        flush = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_advance", ch_advance, 0);
        chk("rst_req", invol_req, 0);
        chk("rst_pwrite", param_write, 0);
        chk("rst_pdata", param_data, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);

        // Table vectors: one channel, one start
        for (int v = 0; v < 6; v++) begin
            reset_all();
            gnt_delay = tbl[v].gdly;
            load_ch(tbl[v].ch, tbl[v].cnt);
            base = obs_w.size();
            ab = adv_t.size();
            d0 = n_done;
            a0 = adv_cnt[tbl[v].ch];
            pulse_start(NSD'(1) << tbl[v].ch);
            model_run();
            wait_idle(3000, $sformatf("vec%0d_idle", v));
            chk($sformatf("vec%0d_hdr_ch", v), word_at(base), {1'b0, 32'(tbl[v].ch)});
            chk($sformatf("vec%0d_hdr_len", v), word_at(base + 1), {1'b1, 32'(tbl[v].exp_len)});
            chk($sformatf("vec%0d_chunks", v), n_done - d0, tbl[v].exp_chunks);
            chk($sformatf("vec%0d_adv_ch", v), adv_cnt[tbl[v].ch] - a0, tbl[v].cnt);
            chk($sformatf("vec%0d_adv_all", v), adv_t.size() - ab, tbl[v].cnt);
            check_stream(base, $sformatf("vec%0d_stream", v));
        end

        // Single channel with exact words, latencies and advance spacing
        reset_all();
        gnt_delay = 5;
        push_byte(2, 8'hA1);
        push_byte(2, 8'hB2);
        push_byte(2, 8'hC3);
        base = obs_w.size();
        ab = adv_t.size();
        d0 = n_done;
        @(negedge clk);
        chk("t1_req_before", invol_req, 0);
        ch_start = 4'b0100;
        @(negedge clk);
        ch_start = '0;
        chk("t1_req_latency", invol_req, 1);
        wait_idle(2000, "t1_idle");
        chk("t1_w0", word_at(base),     {1'b0, 32'd2});
        chk("t1_w1", word_at(base + 1), {1'b1, 32'd3});
        chk("t1_w2", word_at(base + 2), 33'h1_0000_00A1);
        chk("t1_w3", word_at(base + 3), 33'h1_0000_00B2);
        chk("t1_w4", word_at(base + 4), 33'h1_0000_00C3);
        chk("t1_nwords", obs_w.size() - base, 5);
        chk("t1_wr_latency", obs_wc[base] - g_cyc, 1);
        chk("t1_adv_count", adv_t.size() - ab, 3);
        chk("t1_adv_gap1", adv_t[ab + 1] - adv_t[ab], 3);
        chk("t1_adv_gap2", adv_t[ab + 2] - adv_t[ab + 1], 3);
        chk("t1_done", n_done - d0, 1);

        // Chunking of a 150-byte buffer
        reset_all();
        gnt_delay = 1;
        load_ch(0, 150);
        base = obs_w.size();
        d0 = n_done;
        pulse_start(4'b0001);
        model_run();
        wait_idle(3000, "chunk_idle");
        parse_hdrs(base);
        chk("chunk_nhdr", got_ch.size(), 3);
        chk("chunk_len0", got_len[0], 64);
        chk("chunk_len1", got_len[1], 64);
        chk("chunk_len2", got_len[2], 22);
        chk("chunk_ch2", got_ch[2], 0);
        chk("chunk_done", n_done - d0, 3);
        check_stream(base, "chunk_stream");

        // Fairness: channels 0 and 3 start together
        reset_all();
        gnt_delay = 2;
        load_ch(0, 100);
        load_ch(3, 1);
        base = obs_w.size();
        d0 = n_done;
        pulse_start(4'b1001);
        model_run();
        wait_idle(3000, "fair_idle");
        parse_hdrs(base);
        chk("fair_nhdr", got_ch.size(), 3);
        chk("fair_ch0", got_ch[0], 0);
        chk("fair_ch1", got_ch[1], 3);
        chk("fair_ch2", got_ch[2], 0);
        chk("fair_len0", got_len[0], 64);
        chk("fair_len1", got_len[1], 1);
        chk("fair_len2", got_len[2], 36);
        chk("fair_done", n_done - d0, 3);
        check_stream(base, "fair_stream");

        // rr wrap: rr_ptr ends at 3 with channels 0 and 3 pending
        reset_all();
        gnt_delay = 0;
        load_ch(3, 5);
        base = obs_w.size();
        pulse_start(4'b1000);
        wait_adv("wrap_adv");
        load_ch(0, 2);
        load_ch(3, 3);
        pulse_start(4'b1001);
        wait_idle(3000, "wrap_idle");
        parse_hdrs(base);
        chk("wrap_nhdr", got_ch.size(), 3);
        chk("wrap_ch0", got_ch[0], 3);
        chk("wrap_ch1", got_ch[1], 0);
        chk("wrap_ch2", got_ch[2], 3);
        chk("wrap_len1", got_len[1], 2);
        chk("wrap_len2", got_len[2], 3);

        // Reset during a data chunk
        reset_all();
        gnt_delay = 1;
        load_ch(1, 10);
        pulse_start(4'b0010);
        wait_adv("rst_adv_wait");
        chk("rst_pre_adv", ch_advance, 4'b0010);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_adv", ch_advance, 0);
        chk("rst_mid_req", invol_req, 0);
        chk("rst_mid_pwrite", param_write, 0);
        chk("rst_mid_pdata", param_data, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (12) begin
                @(negedge clk);
                if (invol_req || busy) seen++;
            end
            chk("rst_no_req_after", seen, 0);
        end

        // Randomized multi-channel rounds
        for (int r = 0; r < 8; r++) begin
            reset_all();
            gnt_delay = $urandom_range(0, 4);
            mask = '0;
            for (int i = 0; i < NSD; i++) cnts[i] = 0;
            while (mask == '0) begin
                for (int i = 0; i < NSD; i++) begin
                    if (!mask[i] && $urandom_range(0, 1) == 1) begin
                        mask[i] = 1'b1;
                        cnts[i] = $urandom_range(0, 140);
                        load_ch(i, cnts[i]);
                    end
                end
            end
            base = obs_w.size();
            d0 = n_done;
            for (int i = 0; i < NSD; i++) cnts[i] += adv_cnt[i];
            pulse_start(mask);
            model_run();
            wait_idle(8000, $sformatf("rnd%0d_idle", r));
            check_stream(base, $sformatf("rnd%0d_stream", r));
            chk($sformatf("rnd%0d_done", r), n_done - d0, exp_chunks);
            for (int i = 0; i < NSD; i++)
                chk($sformatf("rnd%0d_adv%0d", r, i), adv_cnt[i], cnts[i]);
        end

        chk("adv_onehot", multi_adv, 0);
        chk("rsp_code_on_done", rsp_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sd_out_sched.md
Name: sd_out_sched

Overview:
- Round-robin scheduler that shares the single host response path (involuntary-message request/grant plus param word stream) among NSD SD channel output buffers.
- Each channel raises a start pulse when it has response bytes. The scheduler latches these requests and grants one channel at a time.
- For the granted channel it emits a framed chunk of at most MAX_CHUNK bytes, then re-queues the channel if bytes remain.
- Sits between the per-channel sdc output FIFOs and the host command/response framer, in place of a fixed-priority channel pick.

Parameters:
- NSD, 4, number of SD channels (1..16).
- ADDR_BITS, 11, width of each channel's element count.
- MAX_CHUNK, 64, maximum data bytes per framed chunk (1..2**ADDR_BITS-1).
- RSP_CODE, 0, response id placed on param_data in the FIN state.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ch_start  in  NSD  per-channel one-cycle "output available" pulse.
- ch_elemcnt  in  NSD*ADDR_BITS  per-channel byte count; channel i occupies bits [i*ADDR_BITS +: ADDR_BITS].
- ch_data  in  NSD*8  per-channel head byte; channel i occupies bits [i*8 +: 8].
- ch_advance  out  NSD  one-cycle pop strobe to the selected channel.
- invol_req  out  1  request for the host response path.
- invol_grant  in  1  host grants the response path.
- param_data  out  33  response word.
- param_write  out  1  param_data valid strobe.
- done  out  1  one-cycle end-of-message pulse.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_n=0) clears all of the following immediately, including mid-chunk:
  - outputs ch_advance, invol_req, param_write and done to 0; param_data to 0;
  - pending to 0; rr_ptr to NSD-1, so channel 0 wins first; state to IDLE.
- pending[i] is set on ch_start[i]. A set occurring in the same cycle as a clear of that bit takes priority, so no request is lost.
- States: IDLE, REQ, HDR_CH, HDR_LEN, WAIT1, WAIT2, DATA, FIN.
- IDLE: if pending is nonzero, set invol_req=1 and go to REQ.
- REQ:
  - Hold invol_req until invol_grant=1.
  - On grant: invol_req<=0.
  - sel is the first i with pending[i]=1, searching rr_ptr+1, rr_ptr+2, … modulo NSD. It is evaluated on the grant cycle.
  - Clear pending[sel], set rr_ptr<=sel, go to HDR_CH.
- HDR_CH:
  - param_data<={1'b0, 32-bit zero-extended sel}, param_write=1.
  - len<=min(ch_elemcnt[sel], MAX_CHUNK).
  - rem<=ch_elemcnt[sel]-len.
  - Go to HDR_LEN.
- HDR_LEN: param_data<={1'b1, zeros, len}, param_write=1, go to WAIT1.
- WAIT1, then WAIT2: one cycle each; together they cover the 2-cycle read latency of ch_data after an advance.
- DATA:
  - If len==0, go to FIN.
  - Otherwise:
    - param_data<={1'b1, 24'h0, ch_data[sel]}, param_write=1;
    - ch_advance[sel]=1;
    - len<=len-1;
    - go to WAIT1.
  - Per-byte throughput is therefore 1 byte per 3 cycles.
- FIN:
  - done=1 for one cycle; param_data<=RSP_CODE with param_write=0.
  - If rem!=0, set pending[sel] (re-queue); the rr rotation serves other pending channels first.
  - Go to IDLE.
- A ch_elemcnt of 0 at HDR_CH yields a header with len=0, then FIN directly; no data words, no advance.
- param_write, ch_advance and done are single-cycle pulses. At most one ch_advance bit is set per cycle.
- ch_start for sel during its own chunk sets pending[sel]; it is served again after the current rr rotation.
- Message latency with NSD idle: invol_req rises 1 cycle after ch_start. First param_write occurs 1 cycle after the grant cycle.

Test Plan:
- Single channel: ch_start[2] pulse, elemcnt[2]=3, bytes A1,B2,C3, grant after 5 cycles.
  - Required words: {0,2}, {1,…,3}, then 0x1000000A1, 0x1000000B2, 0x1000000C3.
  - Exactly 3 ch_advance[2] pulses, spaced 3 cycles apart, then one done pulse.
- Chunking: elemcnt[0]=150, MAX_CHUNK=64.
  - Headers show len 64, then 64, then 22.
  - pending[0] re-set after each of the first two FINs; three done pulses in total.
- Fairness: ch_start[0] and ch_start[3] in the same cycle, elemcnt[0]=100, elemcnt[3]=1.
  - Service order is 0 (64 bytes), 3 (1 byte), 0 (36 bytes).
- rr wrap: rr_ptr=3 with pending={1,0,0,1} (bits 3..0) → channel 0 selected. Next selection → channel 3.
- Zero count: ch_start[1] with elemcnt[1]=0 → header words {0,1} and {1,…,0}, then done; no ch_advance.
- Reset mid-chunk: assert rst_n=0 during DATA of a 10-byte chunk.
  - All outputs are 0 in the same cycle; pending is empty.
  - After release, with no ch_start, invol_req stays 0.
